// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped instruction cache fetch stage
// Hits return the instruction in the same cycle; misses refill one line over a req/ack word bus.
module icache_fetch #(
   parameter int               N_Bits    = 32,
   parameter int               LINES     = 16,
   parameter int               WORDS     = 4,
   parameter logic [N_Bits-1:0] NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_Bits-1:0] PC,
   input  logic              flush,
   output logic [N_Bits-1:0] instr,
   output logic              stall,
   output logic              mem_req,
   output logic [N_Bits-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [N_Bits-1:0] mem_rdata
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = N_Bits - IDX_W - OFF_W - 2;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t             state;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tags [LINES];
   logic [N_Bits-1:0]  data [LINES][WORDS];

   logic [TAG_W-1:0]   ref_tag;
   logic [IDX_W-1:0]   ref_idx;
   logic [OFF_W-1:0]   cnt;
   logic               pending;

   logic [OFF_W-1:0]   pc_off;
   logic [IDX_W-1:0]   pc_idx;
   logic [TAG_W-1:0]   pc_tag;
   logic               hit;
   logic               last;
   logic               unused_byte_bits;

   assign pc_off           = PC[OFF_W+1:2];
   assign pc_idx           = PC[IDX_W+OFF_W+1:OFF_W+2];
   assign pc_tag           = PC[N_Bits-1:N_Bits-TAG_W];
   assign unused_byte_bits = ^PC[1:0];

   assign hit   = valid[pc_idx] && (tags[pc_idx] == pc_tag);
   assign last  = (cnt == OFF_W'(WORDS - 1));
   assign stall = (state == REFILL) || !hit;
   assign instr = stall ? NOP_INSTR : data[pc_idx][pc_off];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         valid    <= '0;
         cnt      <= '0;
         pending  <= 1'b0;
         ref_tag  <= '0;
         ref_idx  <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush)
                  valid <= '0;
               if (!hit) begin
                  state    <= REFILL;
                  ref_tag  <= pc_tag;
                  ref_idx  <= pc_idx;
                  cnt      <= '0;
                  mem_req  <= 1'b1;
                  mem_addr <= {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
               end
            end
            REFILL: begin
               if (flush)
                  pending <= 1'b1;
               if (mem_ack) begin
                  cnt <= cnt + 1'b1;
                  if (last) begin
                     state    <= IDLE;
                     mem_req  <= 1'b0;
                     mem_addr <= '0;
                     pending  <= 1'b0;
                     // A flush seen during the refill also kills the line just fetched
                     if (pending || flush)
                        valid <= '0;
                     else
                        valid[ref_idx] <= 1'b1;
                  end else begin
                     mem_addr <= mem_addr + N_Bits'(4);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (state == REFILL && mem_ack) begin
         data[ref_idx][cnt] <= mem_rdata;
         if (last)
            tags[ref_idx] <= ref_tag;
      end
   end

endmodule
